// File: rtl/iot_pio_in_irq.sv
// Avalon-MM input PIO: synchronizes and optionally debounces external pins,
// captures selected edges and raises a maskable level interrupt.
module iot_pio_in_irq #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;

    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] edge_clr;
    logic             wr_en;
    logic             unused_wdata;

    // Bits of writedata above WIDTH-1 have no destination.
    assign unused_wdata = ^writedata;

    // Per-bit debounce: a new level is accepted after DEBOUNCE_CYCLES differing cycles.
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_comb begin
                stable_d = sync2_q;
            end
        end else begin : g_debounce
            localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q [WIDTH];
            logic [CNT_W-1:0] cnt_d [WIDTH];

            always_comb begin
                stable_d = stable_q;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    cnt_d[i] = '0;
                    if (sync2_q[i] != stable_q[i]) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            stable_d[i] = sync2_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // Synchronizer, edge detection and register updates.
    always_comb begin
        sync1_d      = in_port;
        sync2_d      = sync1_q;
        stable_dly_d = stable_q;

        if (EDGE_TYPE == 0) begin
            edge_det = stable_q & ~stable_dly_q;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~stable_q & stable_dly_q;
        end else begin
            edge_det = stable_q ^ stable_dly_q;
        end

        wr_en    = chipselect & ~write_n;
        wr_data  = writedata[WIDTH-1:0];
        edge_clr = '0;
        irq_mask_d = irq_mask_q;
        if (wr_en && (address == ADDR_MASK)) begin
            irq_mask_d = wr_data;
        end
        if (wr_en && (address == ADDR_EDGE)) begin
            edge_clr = wr_data;
        end
        // A new edge wins over a simultaneous write-one-to-clear.
        edge_capture_d = (edge_capture_q & ~edge_clr) | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            stable_q       <= '0;
            stable_dly_q   <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            stable_q       <= stable_d;
            stable_dly_q   <= stable_dly_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
        end
    end

    // Zero-wait-state read mux, independent of chipselect.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata = DATA_W'(stable_q);
            ADDR_MASK: readdata = DATA_W'(irq_mask_q);
            ADDR_EDGE: readdata = DATA_W'(edge_capture_q);
            default:   readdata = '0;
        endcase
    end

    assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_iot_pio_in_irq.sv
// Directed bench for iot_pio_in_irq: four instances cover rising/falling/any
// edge capture without debounce and rising capture with a 3-cycle debounce.
module tb_iot_pio_in_irq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic [3:0]  cs;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  pins [4];
    logic [31:0] rdata [4];
    logic [3:0]  irq_v;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    iot_pio_in_irq #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
        .write_n(write_n), .writedata(writedata), .in_port(pins[0]),
        .readdata(rdata[0]), .irq(irq_v[0])
    );
    iot_pio_in_irq #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
        .write_n(write_n), .writedata(writedata), .in_port(pins[1]),
        .readdata(rdata[1]), .irq(irq_v[1])
    );
    iot_pio_in_irq #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
        .write_n(write_n), .writedata(writedata), .in_port(pins[2]),
        .readdata(rdata[2]), .irq(irq_v[2])
    );
    iot_pio_in_irq #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(3)) u_deb (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[3]),
        .write_n(write_n), .writedata(writedata), .in_port(pins[3]),
        .readdata(rdata[3]), .irq(irq_v[3])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input int d, input logic [1:0] a,
                           input logic [31:0] exp);
        address = a;
        #1;
        check(tag, rdata[d], exp);
    endtask

    task automatic chk_irq(input string tag, input int d, input logic exp);
        check(tag, 32'(irq_v[d]), 32'(exp));
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
        address   = a;
        writedata = v;
        cs[d]     = 1'b1;
        write_n   = 1'b0;
        tick(1);
        cs        = '0;
        write_n   = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = 2'd0;
        cs        = '0;
        write_n   = 1'b1;
        writedata = '0;
        for (int i = 0; i < 4; i++) pins[i] = 4'h0;
        tick(3);
        reset_n = 1'b1;
        tick(1);

        // Reset state
        chk_reg("rst_data", 0, 2'd0, 32'h0);
        chk_reg("rst_mask", 0, 2'd2, 32'h0);
        chk_reg("rst_edge", 0, 2'd3, 32'h0);
        chk_irq("rst_irq", 0, 1'b0);

        // Rising capture, no debounce: 4-edge latency
        pins[0] = 4'b0101;
        tick(2);
        chk_reg("rise_data_e2", 0, 2'd0, 32'h0);
        tick(1);
        chk_reg("rise_data_e3", 0, 2'd0, 32'h5);
        chk_reg("rise_edge_e3", 0, 2'd3, 32'h0);
        tick(1);
        chk_reg("rise_edge_e4", 0, 2'd3, 32'h5);
        chk_irq("rise_irq_masked", 0, 1'b0);
        chk_reg("reserved_rd", 0, 2'd1, 32'h0);
        wr(0, 2'd2, 32'h4);
        chk_irq("unmask_irq", 0, 1'b1);
        chk_reg("mask_rd", 0, 2'd2, 32'h4);
        wr(0, 2'd3, 32'h4);
        chk_reg("w1c_edge", 0, 2'd3, 32'h1);
        chk_irq("w1c_irq", 0, 1'b0);
        wr(0, 2'd0, 32'hF);
        chk_reg("data_ro", 0, 2'd0, 32'h5);

        // Upper writedata bits ignored
        wr(1, 2'd2, 32'hFFFF_FFF0);
        chk_reg("mask_upper", 1, 2'd2, 32'h0);

        // Falling vs any on bit0
        pins[1] = 4'h1;
        pins[2] = 4'h1;
        tick(3);
        chk_reg("fa_data", 1, 2'd0, 32'h1);
        chk_reg("any_edge_e3", 2, 2'd3, 32'h0);
        tick(1);
        chk_reg("any_rise_cap", 2, 2'd3, 32'h1);
        chk_reg("fall_no_rise", 1, 2'd3, 32'h0);
        wr(2, 2'd3, 32'h1);
        chk_reg("any_clr", 2, 2'd3, 32'h0);
        pins[1] = 4'h0;
        pins[2] = 4'h0;
        tick(3);
        chk_reg("fall_edge_e3", 1, 2'd3, 32'h0);
        tick(1);
        chk_reg("fall_cap", 1, 2'd3, 32'h1);
        chk_reg("any_fall_cap", 2, 2'd3, 32'h1);

        // Debounce D=3: 2-cycle glitch rejected
        pins[3] = 4'h2;
        tick(2);
        pins[3] = 4'h0;
        tick(8);
        chk_reg("glitch_data", 3, 2'd0, 32'h0);
        chk_reg("glitch_edge", 3, 2'd3, 32'h0);

        // 5-cycle pulse: stable rises 3 cycles after sync2
        pins[3] = 4'h2;
        tick(4);
        chk_reg("deb_data_e4", 3, 2'd0, 32'h0);
        tick(1);
        chk_reg("deb_data_e5", 3, 2'd0, 32'h2);
        pins[3] = 4'h0;
        tick(1);
        chk_reg("deb_edge", 3, 2'd3, 32'h2);
        tick(8);
        chk_reg("deb_fall_data", 3, 2'd0, 32'h0);

        // Same-cycle W1C and new rising edge on bit2 (mask 0x4)
        pins[0] = 4'b0001;
        tick(4);
        pins[0] = 4'b0101;
        tick(4);
        chk_reg("coll_pre_edge", 0, 2'd3, 32'h5);
        chk_irq("coll_pre_irq", 0, 1'b1);
        pins[0] = 4'b0001;
        tick(4);
        pins[0] = 4'b0101;
        tick(3);
        wr(0, 2'd3, 32'h4);
        chk_reg("coll_edge", 0, 2'd3, 32'h5);
        chk_irq("coll_irq", 0, 1'b1);
        tick(1);
        chk_irq("coll_irq_hold", 0, 1'b1);

        // Async reset mid-debounce with irq active
        pins[3] = 4'h1;
        tick(3);
        reset_n = 1'b0;
        #1;
        chk_irq("arst_irq", 0, 1'b0);
        chk_reg("arst_edge", 0, 2'd3, 32'h0);
        chk_reg("arst_mask", 0, 2'd2, 32'h0);
        chk_reg("arst_data", 0, 2'd0, 32'h0);
        pins[0] = 4'hF;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        chk_reg("rel_data", 0, 2'd0, 32'hF);
        chk_reg("rel_edge_e3", 0, 2'd3, 32'h0);
        tick(1);
        chk_reg("rel_edge_e4", 0, 2'd3, 32'hF);
        chk_irq("rel_irq", 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
